// File: rtl/alu_pkg.sv
// Shared op codes and sequencer state encoding for the ALU execute stage.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b110;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier datapath; the sequencer owns iteration count and sequencing.
module alu_shift_add_mul #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] product_o
);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_step;

   // Accumulator value after the current step, so the final step's sum is visible same edge.
   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign product_o = acc_step;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (load_i) begin
         mcand_d  = a_i;
         mplier_d = b_i;
         acc_d    = '0;
      end else if (step_i) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_step;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer: single-cycle logic/arith ops plus a stalling WIDTH-cycle shift-add MUL.
module alu_exec_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [2:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   input  logic             flush_i,
   output logic             ready_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   alu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             mul_load, mul_step;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] single_res;

   // Unused codes (000, 101, 111) fall through to ADD.
   function automatic logic [WIDTH-1:0] single_op(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
      case (op)
         ALU_SUB: single_op = a - b;
         ALU_AND: single_op = a & b;
         ALU_OR:  single_op = a | b;
         default: single_op = a + b;
      endcase
   endfunction

   assign single_res = single_op(ALUCtrl_i, src1_i, src2_i);

   assign ready_o  = (state_q != ST_MUL);
   assign stall_o  = (state_q == ST_MUL);
   assign done_o   = done_q;
   assign result_o = result_q;
   assign zero_o   = zero_q;

   alu_shift_add_mul #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (mul_load),
      .step_i    (mul_step),
      .a_i       (src1_i),
      .b_i       (src2_i),
      .product_o (mul_product)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      mul_load = 1'b0;
      mul_step = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  if (ALUCtrl_i == ALU_MUL) begin
                     state_d  = ST_MUL;
                     cnt_d    = '0;
                     mul_load = 1'b1;
                  end else begin
                     result_d = single_res;
                     zero_d   = (single_res == '0);
                     done_d   = 1'b1;
                  end
               end
            end
            ST_MUL: begin
               mul_step = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d  = ST_IDLE;
                  cnt_d    = '0;
                  result_d = mul_product;
                  zero_d   = (mul_product == '0);
                  done_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench: vector table, directed MUL/flush/reset sequences, random run vs. reference model.
module tb_alu_exec_sequencer;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic [2:0]       ALUCtrl_i = 3'b001;
   logic [WIDTH-1:0] src1_i = '0;
   logic [WIDTH-1:0] src2_i = '0;
   logic             flush_i = 1'b0;
   logic             ready_o, stall_o, done_o, zero_o;
   logic [WIDTH-1:0] result_o;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state
   int               m_busy = 0;
   logic [WIDTH-1:0] m_pending = '0;
   logic [WIDTH-1:0] m_result = '0;
   logic             m_zero = 1'b0;
   logic             m_done = 1'b0;

   always #5 clk = ~clk;

   alu_exec_sequencer #(.WIDTH(WIDTH)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .ALUCtrl_i (ALUCtrl_i),
      .src1_i    (src1_i),
      .src2_i    (src2_i),
      .flush_i   (flush_i),
      .ready_o   (ready_o),
      .stall_o   (stall_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .zero_o    (zero_o)
   );

   function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (op)
         3'b010:  return a - b;
         3'b011:  return a & b;
         3'b100:  return a | b;
         3'b110:  return a * b;
         default: return a + b;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Advance one clock: update the model from the inputs presented to this edge, then compare.
   task automatic cycle();
      if (rst_i) begin
         m_busy = 0; m_result = '0; m_zero = 1'b0; m_done = 1'b0;
      end else if (flush_i) begin
         m_busy = 0; m_done = 1'b0;
      end else if (m_busy > 0) begin
         m_busy--;
         m_done = (m_busy == 0);
         if (m_busy == 0) begin
            m_result = m_pending;
            m_zero   = (m_pending == '0);
         end
      end else begin
         m_done = 1'b0;
         if (start_i) begin
            if (ALUCtrl_i == 3'b110) begin
               m_busy    = WIDTH;
               m_pending = src1_i * src2_i;
            end else begin
               m_result = ref_op(ALUCtrl_i, src1_i, src2_i);
               m_zero   = (m_result == '0);
               m_done   = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("model_ready",  WIDTH'(ready_o), WIDTH'(m_busy == 0));
      chk("model_stall",  WIDTH'(stall_o), WIDTH'(m_busy != 0));
      chk("model_done",   WIDTH'(done_o),  WIDTH'(m_done));
      chk("model_result", result_o, m_result);
      chk("model_zero",   WIDTH'(zero_o),  WIDTH'(m_zero));
   endtask

   task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start_i = 1'b1; ALUCtrl_i = op; src1_i = a; src2_i = b;
      cycle();
      start_i = 1'b0;
   endtask

   // Runs a MUL to completion, returning stall-cycle count and done-pulse count seen.
   task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int poke_at, output int n_stall, output int n_done);
      n_stall = 0; n_done = 0;
      issue(3'b110, a, b);
      while (stall_o && n_stall < 64) begin
         n_stall++;
         chk("mul_ready_low", WIDTH'(ready_o), 0);
         if (done_o) n_done++;
         if (n_stall == poke_at) begin
            start_i = 1'b1; ALUCtrl_i = 3'b001; src1_i = 1; src2_i = 1;
         end
         cycle();
         start_i = 1'b0;
      end
      if (done_o) n_done++;
   endtask

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp;
      logic             exp_zero;
   } vec_t;

   vec_t vt[$];

   initial begin
      int ns, nd;
      vt.push_back('{3'b001, 32'd5, 32'd7, 32'd12, 1'b0});
      vt.push_back('{3'b010, 32'd7, 32'd7, 32'd0, 1'b1});
      vt.push_back('{3'b010, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0});
      vt.push_back('{3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0});
      vt.push_back('{3'b100, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0});
      vt.push_back('{3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1});
      vt.push_back('{3'b101, 32'd100, 32'd23, 32'd123, 1'b0});
      vt.push_back('{3'b111, 32'h8000_0000, 32'h8000_0001, 32'd1, 1'b0});

      // Reset state
      rst_i = 1'b1;
      cycle(); cycle();
      rst_i = 1'b0;
      chk("rst_ready", WIDTH'(ready_o), 1);
      chk("rst_stall", WIDTH'(stall_o), 0);
      chk("rst_done", WIDTH'(done_o), 0);
      chk("rst_result", result_o, 0);
      chk("rst_zero", WIDTH'(zero_o), 0);

      // Back-to-back single-cycle ops: done every cycle
      foreach (vt[i]) begin
         issue(vt[i].op, vt[i].a, vt[i].b);
         chk($sformatf("vec%0d_done", i), WIDTH'(done_o), 1);
         chk($sformatf("vec%0d_result", i), result_o, vt[i].exp);
         chk($sformatf("vec%0d_zero", i), WIDTH'(zero_o), WIDTH'(vt[i].exp_zero));
         chk($sformatf("vec%0d_ready", i), WIDTH'(ready_o), 1);
      end
      cycle();
      chk("idle_done_low", WIDTH'(done_o), 0);

      // MUL 6*7 with an ignored start mid-operation
      run_mul(32'd6, 32'd7, 10, ns, nd);
      chk("mul42_stall_cycles", ns, 32);
      chk("mul42_done_count", nd, 1);
      chk("mul42_result", result_o, 42);
      chk("mul42_zero", WIDTH'(zero_o), 0);
      cycle();
      chk("mul42_done_drop", WIDTH'(done_o), 0);

      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, ns, nd);
      chk("mulff_result", result_o, 32'h0000_0001);
      run_mul(32'h0001_0000, 32'h0001_0000, 0, ns, nd);
      chk("mul64k_result", result_o, 0);
      chk("mul64k_zero", WIDTH'(zero_o), 1);

      // Flush at the 10th MUL cycle
      issue(3'b001, 32'd1, 32'd2);
      issue(3'b110, 32'd9, 32'd9);
      repeat (9) cycle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      chk("flush_stall", WIDTH'(stall_o), 0);
      chk("flush_ready", WIDTH'(ready_o), 1);
      chk("flush_done", WIDTH'(done_o), 0);
      chk("flush_result_kept", result_o, 3);
      repeat (2) cycle();
      chk("flush_no_late_done", WIDTH'(done_o), 0);
      issue(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("post_flush_and", result_o, 32'h00F0_00F0);

      // Flush on the final MUL edge suppresses its done
      issue(3'b110, 32'd5, 32'd5);
      repeat (31) cycle();
      flush_i = 1'b1;
      cycle();
      flush_i = 1'b0;
      chk("lastflush_done", WIDTH'(done_o), 0);
      chk("lastflush_result", result_o, 32'h00F0_00F0);
      chk("lastflush_ready", WIDTH'(ready_o), 1);

      // Reset at the 20th MUL cycle with start held high
      issue(3'b110, 32'd3, 32'd4);
      repeat (19) cycle();
      rst_i = 1'b1; start_i = 1'b1; ALUCtrl_i = 3'b001;
      cycle();
      rst_i = 1'b0; start_i = 1'b0;
      chk("midrst_ready", WIDTH'(ready_o), 1);
      chk("midrst_stall", WIDTH'(stall_o), 0);
      chk("midrst_done", WIDTH'(done_o), 0);
      chk("midrst_result", result_o, 0);
      chk("midrst_zero", WIDTH'(zero_o), 0);
      issue(3'b100, 32'h1, 32'h2);
      chk("post_rst_or", result_o, 32'h3);
      chk("post_rst_or_done", WIDTH'(done_o), 1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         start_i   = ($urandom_range(99) < 55);
         ALUCtrl_i = 3'($urandom_range(7));
         if ($urandom_range(3) == 0) begin
            src1_i = 32'($urandom_range(3));
            src2_i = 32'($urandom_range(3));
         end else begin
            src1_i = $urandom;
            src2_i = $urandom;
         end
         flush_i = ($urandom_range(99) < 2);
         rst_i   = ($urandom_range(499) == 0);
         cycle();
      end
      start_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
